// File: rtl/rvv_backend_dispatch_issue_reg_pkg.sv
// Shared dispatch types: uop payload, structure-hazard flags, slot occupancy.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Defines `NUM_DP_UOP (dispatch width, 2) if the build has not already set it.
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

package rvv_backend_dispatch_issue_reg_pkg;

    typedef struct packed {
        logic [31:0] uop_pc;
        logic [5:0]  uop_funct6;
        logic [4:0]  vd_index;
        logic [4:0]  vs1_index;
        logic [4:0]  vs2_index;
        logic [7:0]  uop_id;
    } STRCT_UOP_t;

    typedef struct packed {
        logic vr_limit;
        logic pu_limit;
    } ARCH_HAZARD_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // 0 -> 00, 1 -> 01, 2 -> 11.
    function automatic logic [1:0] therm2(input logic [1:0] n);
        logic [1:0] t;
        t = 2'b00;
        if (n != 2'd0) t[0] = 1'b1;
        if (n == 2'd2) t[1] = 1'b1;
        return t;
    endfunction

endpackage

// File: rtl/rvv_backend_dispatch_perf_cnt.sv
// Saturating 32-bit counters of cycles where a structure hazard alone cut dispatch to one uop.
// Latency: count visible one cycle after the qualifying cycle.
// Backpressure: none; observes only, never stalls.
// Ports: clk, rst_n; uop1_vld, vr_limit, pu_limit, free_is_two (qualifiers); cnt_vr_limit, cnt_pu_limit (counts).
// Instantiated only when DISPATCH_HAZARD_PERF_CNT_EN is defined.
module rvv_backend_dispatch_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uop1_vld,
    input  logic        vr_limit,
    input  logic        pu_limit,
    input  logic        free_is_two,
    output logic [31:0] cnt_vr_limit,
    output logic [31:0] cnt_pu_limit
);

    logic [31:0] cnt_vr_q, cnt_vr_d;
    logic [31:0] cnt_pu_q, cnt_pu_d;
    logic        inc_vr, inc_pu;

    always_comb begin
        // Only count when both slots were free, i.e. the hazard was the sole limiter.
        // vr_limit takes priority so each lost cycle is attributed once.
        inc_vr   = uop1_vld & vr_limit & free_is_two;
        inc_pu   = uop1_vld & pu_limit & ~vr_limit & free_is_two;
        cnt_vr_d = cnt_vr_q;
        cnt_pu_d = cnt_pu_q;
        if (inc_vr && (cnt_vr_q != 32'hFFFF_FFFF)) cnt_vr_d = cnt_vr_q + 32'd1;
        if (inc_pu && (cnt_pu_q != 32'hFFFF_FFFF)) cnt_pu_d = cnt_pu_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_vr_q <= 32'd0;
            cnt_pu_q <= 32'd0;
        end else begin
            cnt_vr_q <= cnt_vr_d;
            cnt_pu_q <= cnt_pu_d;
        end
    end

    assign cnt_vr_limit = cnt_vr_q;
    assign cnt_pu_limit = cnt_pu_q;

endmodule

// File: rtl/rvv_backend_dispatch_issue_reg.sv
// Two-slot dispatch issue register between the uop queue and the reservation stations.
// Latency: one cycle from acceptance (uop_ready_dp2uop) to uop_valid_dp2rs; 2 uops/cycle sustained.
// Backpressure: accepts min(free slots, hazard limit, queued uops) per cycle, computed combinationally.
// Ports: clk, rst_n; uop_valid_uop2dp/uop_uop2dp/uop_ready_dp2uop (queue side);
//        arch_hazard; uop_valid_dp2rs/uop_dp2rs/uop_ready_rs2dp (RS side); trap_flush_rvv.
// Optional: DISPATCH_HAZARD_PERF_CNT_EN adds cnt_vr_limit/cnt_pu_limit hazard counters.
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

module rvv_backend_dispatch_issue_reg
    import rvv_backend_dispatch_issue_reg_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [`NUM_DP_UOP-1:0] uop_valid_uop2dp,
    input  STRCT_UOP_t             uop_uop2dp [`NUM_DP_UOP],
    input  ARCH_HAZARD_t           arch_hazard,
    output logic [`NUM_DP_UOP-1:0] uop_ready_dp2uop,
    output logic [`NUM_DP_UOP-1:0] uop_valid_dp2rs,
    output STRCT_UOP_t             uop_dp2rs [`NUM_DP_UOP],
    input  logic [`NUM_DP_UOP-1:0] uop_ready_rs2dp,
    input  logic                   trap_flush_rvv
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]            cnt_vr_limit,
    output logic [31:0]            cnt_pu_limit
`endif
);

    generate
        if (`NUM_DP_UOP != 2) begin : g_bad_width
            $error("rvv_backend_dispatch_issue_reg supports only NUM_DP_UOP == 2");
        end
    endgenerate

    occ_e       state_q, state_d;
    STRCT_UOP_t slot_q [2];
    STRCT_UOP_t slot_d [2];
    logic [1:0] slot_load;

    logic [1:0] valid_slot;
    logic [1:0] occ_cnt;
    logic       drain0, drain1, shift;
    logic [1:0] remain, free, limit, q_cnt, acc_n;

    always_comb begin
        valid_slot = 2'b00;
        occ_cnt    = 2'd0;
        case (state_q)
            OCC_ONE: begin valid_slot = 2'b01; occ_cnt = 2'd1; end
            OCC_TWO: begin valid_slot = 2'b11; occ_cnt = 2'd2; end
            default: begin valid_slot = 2'b00; occ_cnt = 2'd0; end
        endcase

        // Slots retire in order: slot1 can only leave together with slot0.
        drain0 = valid_slot[0] & uop_ready_rs2dp[0];
        drain1 = valid_slot[1] & uop_ready_rs2dp[1] & drain0;
        remain = occ_cnt - {1'b0, drain0} - {1'b0, drain1};
        free   = 2'd2 - remain;
        limit  = (arch_hazard.vr_limit | arch_hazard.pu_limit) ? 2'd1 : 2'd2;

        // Leading-ones count of the queue valids; equals the popcount because the
        // queue presents entries in order. Built from valid bits only, never payload.
        q_cnt = uop_valid_uop2dp[0] ? (uop_valid_uop2dp[1] ? 2'd2 : 2'd1) : 2'd0;

        acc_n = free;
        if (limit < acc_n) acc_n = limit;
        if (q_cnt < acc_n) acc_n = q_cnt;
        if (trap_flush_rvv || !rst_n) acc_n = 2'd0;

        // Exactly one of two occupied slots left: old slot1 becomes the oldest.
        shift = drain0 & ~drain1 & valid_slot[1];

        state_d   = state_q;
        slot_d[0] = slot_q[0];
        slot_d[1] = slot_q[1];
        slot_load = 2'b00;

        if (trap_flush_rvv) begin
            state_d = OCC_EMPTY;
        end else begin
            case (remain)
                2'd0: begin
                    slot_d[0]    = uop_uop2dp[0];
                    slot_d[1]    = uop_uop2dp[1];
                    slot_load[0] = (acc_n != 2'd0);
                    slot_load[1] = (acc_n == 2'd2);
                end
                2'd1: begin
                    if (shift) begin
                        slot_d[0]    = slot_q[1];
                        slot_load[0] = 1'b1;
                    end
                    slot_d[1]    = uop_uop2dp[0];
                    slot_load[1] = (acc_n != 2'd0);
                end
                default: begin
                    slot_load = 2'b00;
                end
            endcase

            case (remain + acc_n)
                2'd0:    state_d = OCC_EMPTY;
                2'd1:    state_d = OCC_ONE;
                default: state_d = OCC_TWO;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= OCC_EMPTY;
        else        state_q <= state_d;
    end

    // Payloads are qualified by the slot valids, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (slot_load[i]) slot_q[i] <= slot_d[i];
        end
    end

    always_comb begin
        uop_ready_dp2uop = therm2(acc_n);
        uop_valid_dp2rs  = valid_slot;
        for (int i = 0; i < 2; i++) uop_dp2rs[i] = slot_q[i];
    end

`ifdef DISPATCH_HAZARD_PERF_CNT_EN
    rvv_backend_dispatch_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .uop1_vld     (uop_valid_uop2dp[1]),
        .vr_limit     (arch_hazard.vr_limit),
        .pu_limit     (arch_hazard.pu_limit),
        .free_is_two  (free == 2'd2),
        .cnt_vr_limit (cnt_vr_limit),
        .cnt_pu_limit (cnt_pu_limit)
    );
`endif

endmodule

// File: tb/tb_rvv_backend_dispatch_issue_reg.sv
// Randomized scoreboard bench for the dispatch issue register.
// The reference model is an ordered queue of in-flight uops (exp_q); the monitor
// pops it whenever a slot is handed to the reservation stations.
`ifndef NUM_DP_UOP
`define NUM_DP_UOP 2
`endif

module tb_rvv_backend_dispatch_issue_reg;
    import rvv_backend_dispatch_issue_reg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   uop_valid_uop2dp;
    STRCT_UOP_t   uop_uop2dp [`NUM_DP_UOP];
    ARCH_HAZARD_t arch_hazard;
    logic [1:0]   uop_ready_dp2uop;
    logic [1:0]   uop_valid_dp2rs;
    STRCT_UOP_t   uop_dp2rs [`NUM_DP_UOP];
    logic [1:0]   uop_ready_rs2dp;
    logic         trap_flush_rvv;
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
    logic [31:0]  cnt_vr_limit;
    logic [31:0]  cnt_pu_limit;
`endif

    always #5 clk = ~clk;

    rvv_backend_dispatch_issue_reg dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .uop_valid_uop2dp (uop_valid_uop2dp),
        .uop_uop2dp       (uop_uop2dp),
        .arch_hazard      (arch_hazard),
        .uop_ready_dp2uop (uop_ready_dp2uop),
        .uop_valid_dp2rs  (uop_valid_dp2rs),
        .uop_dp2rs        (uop_dp2rs),
        .uop_ready_rs2dp  (uop_ready_rs2dp),
        .trap_flush_rvv   (trap_flush_rvv)
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
        ,
        .cnt_vr_limit     (cnt_vr_limit),
        .cnt_pu_limit     (cnt_pu_limit)
`endif
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    int         next_id = 0;
    int         m_cnt_vr = 0;
    int         m_cnt_pu = 0;
    logic [1:0] last_rdy;
    STRCT_UOP_t src_q [$];
    STRCT_UOP_t exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] therm(input int n);
        return (n <= 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    endfunction

    function automatic STRCT_UOP_t new_uop();
        STRCT_UOP_t u;
        u.uop_pc     = $urandom;
        u.uop_funct6 = 6'($urandom_range(0, 63));
        u.vd_index   = 5'($urandom_range(0, 31));
        u.vs1_index  = 5'($urandom_range(0, 31));
        u.vs2_index  = 5'($urandom_range(0, 31));
        u.uop_id     = 8'(next_id);
        next_id++;
        return u;
    endfunction

    // Monitor: at negedge+2, check the slot valids against the model occupancy and
    // compare every slot the RS takes this cycle against the oldest expected uop.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                int         occ;
                bit         d0, d1;
                STRCT_UOP_t e;
                occ = exp_q.size();
                check("valid_dp2rs", 64'(uop_valid_dp2rs), 64'(therm(occ)));
                d0 = (occ >= 1) && uop_ready_rs2dp[0];
                d1 = (occ == 2) && uop_ready_rs2dp[1] && d0;
                if (d0) begin
                    e = exp_q.pop_front();
                    check("slot0_payload", 64'(uop_dp2rs[0]), 64'(e));
                end
                if (d1) begin
                    e = exp_q.pop_front();
                    check("slot1_payload", 64'(uop_dp2rs[1]), 64'(e));
                end
            end
        end
    end

    // One clock of stimulus: drive at negedge, check the pop request at +1,
    // then (after the monitor at +2) advance the model at +3.
    task automatic do_cycle(input int vcnt, input bit vr, input bit pu,
                            input logic [1:0] rdy, input bit fl);
        int occ, remain, free, lim, n;
        bit d0, d1;
        @(negedge clk);
        while (src_q.size() < 2) src_q.push_back(new_uop());
        uop_valid_uop2dp     = therm(vcnt);
        uop_uop2dp[0]        = src_q[0];
        uop_uop2dp[1]        = src_q[1];
        arch_hazard.vr_limit = vr;
        arch_hazard.pu_limit = pu;
        uop_ready_rs2dp      = rdy;
        trap_flush_rvv       = fl;
        #1;
        occ    = exp_q.size();
        d0     = (occ >= 1) && rdy[0];
        d1     = (occ == 2) && rdy[1] && d0;
        remain = occ - int'(d0) - int'(d1);
        free   = 2 - remain;
        lim    = (vr || pu) ? 1 : 2;
        n      = free;
        if (lim < n)  n = lim;
        if (vcnt < n) n = vcnt;
        if (fl)       n = 0;
        last_rdy = uop_ready_dp2uop;
        check("ready_dp2uop", 64'(uop_ready_dp2uop), 64'(therm(n)));
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
        check("cnt_vr_limit", 64'(cnt_vr_limit), 64'(m_cnt_vr));
        check("cnt_pu_limit", 64'(cnt_pu_limit), 64'(m_cnt_pu));
        if (vcnt == 2 && vr && free == 2)        m_cnt_vr++;
        if (vcnt == 2 && pu && !vr && free == 2) m_cnt_pu++;
`endif
        #2;
        if (fl) exp_q.delete();
        else for (int i = 0; i < n; i++) exp_q.push_back(src_q.pop_front());
    endtask

    task automatic idle_inputs();
        uop_valid_uop2dp     = 2'b00;
        arch_hazard.vr_limit = 1'b0;
        arch_hazard.pu_limit = 1'b0;
        uop_ready_rs2dp      = 2'b00;
        trap_flush_rvv       = 1'b0;
    endtask

    initial begin
        int total;
        rst_n = 1'b0;
        idle_inputs();
        uop_valid_uop2dp = 2'b11;
        uop_uop2dp[0] = new_uop();
        uop_uop2dp[1] = new_uop();
        src_q.push_back(uop_uop2dp[0]);
        src_q.push_back(uop_uop2dp[1]);
        #12;
        check("reset_valid_dp2rs", 64'(uop_valid_dp2rs), 64'(2'b00));
        check("reset_ready_dp2uop", 64'(uop_ready_dp2uop), 64'(2'b00));
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
        check("reset_cnt_vr", 64'(cnt_vr_limit), 64'd0);
        check("reset_cnt_pu", 64'(cnt_pu_limit), 64'd0);
`endif
        @(negedge clk);
        idle_inputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Full-rate streaming: 8 cycles should move 16 uops.
        total = 0;
        for (int i = 0; i < 8; i++) begin
            do_cycle(2, 0, 0, 2'b11, 0);
            total += $countones(last_rdy);
        end
        check("throughput_8cyc", 64'(total), 64'd16);

        // Drain, then a vr hazard from EMPTY admits exactly one uop.
        do_cycle(0, 0, 0, 2'b11, 0);
        do_cycle(2, 1, 0, 2'b00, 0);
        check("vr_limit_ready", 64'(last_rdy), 64'(2'b01));
        // ONE -> TWO with one free slot.
        do_cycle(2, 0, 0, 2'b00, 0);
        // TWO, rs_ready=10: slot1 readiness alone is ignored, nothing moves.
        do_cycle(2, 0, 0, 2'b10, 0);
        check("rs10_ready", 64'(last_rdy), 64'(2'b00));
        // TWO, rs_ready=01: shift slot1 down, one new uop into slot1.
        do_cycle(2, 0, 0, 2'b01, 0);
        check("rs01_ready", 64'(last_rdy), 64'(2'b01));
        // Flush wins over simultaneous drain and acceptance.
        do_cycle(2, 0, 0, 2'b11, 1);
        check("flush_ready", 64'(last_rdy), 64'(2'b00));
        do_cycle(0, 0, 0, 2'b00, 0);
        // pu hazard from EMPTY.
        do_cycle(2, 0, 1, 2'b00, 0);
        do_cycle(0, 0, 0, 2'b11, 0);
        do_cycle(0, 0, 0, 2'b11, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            do_cycle($urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 31) == 0));
        end

        // Reach TWO, then assert reset between clock edges.
        do_cycle(0, 0, 0, 2'b11, 0);
        do_cycle(0, 0, 0, 2'b11, 0);
        do_cycle(2, 1, 0, 2'b00, 0);
        do_cycle(2, 0, 0, 2'b00, 0);
        @(negedge clk);
        mon_en = 1'b0;
        idle_inputs();
        uop_valid_uop2dp = 2'b11;
        #1;
        check("pre_reset_two", 64'(uop_valid_dp2rs), 64'(therm(exp_q.size())));
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_valid_dp2rs", 64'(uop_valid_dp2rs), 64'(2'b00));
        check("midreset_ready_dp2uop", 64'(uop_ready_dp2uop), 64'(2'b00));
`ifdef DISPATCH_HAZARD_PERF_CNT_EN
        check("midreset_cnt_vr", 64'(cnt_vr_limit), 64'd0);
        check("midreset_cnt_pu", 64'(cnt_pu_limit), 64'd0);
`endif
        exp_q.delete();
        m_cnt_vr = 0;
        m_cnt_pu = 0;
        @(negedge clk);
        idle_inputs();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 60; i++) begin
            do_cycle($urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), 1'b0);
        end
        do_cycle(0, 0, 0, 2'b11, 0);
        do_cycle(0, 0, 0, 2'b11, 0);
        @(negedge clk);
        #4;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
